// File: rtl/gf_pcpi_pkg.sv
// Shared types and constants for the PCPI initiator.
// Includes an R-type instruction builder.
package gf_pcpi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP
    } state_t;

    localparam logic [6:0] OPCODE_R = 7'b0110011;
    localparam logic [6:0] FUNCT7_G = 7'b0000100;
    localparam logic [6:0] FUNCT7_M = 7'b0000001;

    function automatic logic [31:0] mk_rtype(
        input logic [6:0] funct7,
        input logic [4:0] rs2,
        input logic [4:0] rs1,
        input logic [2:0] funct3,
        input logic [4:0] rd
    );
        return {funct7, rs2, rs1, funct3, rd, OPCODE_R};
    endfunction

endpackage

// File: rtl/gf_pcpi_initiator.sv
// PCPI master: issues one host command at a time to a coprocessor,
// applies wait/timeout semantics and returns the result or a timeout.
module gf_pcpi_initiator
    import gf_pcpi_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_insn,
    input  logic [31:0]      cmd_rs1,
    input  logic [31:0]      cmd_rs2,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rd,
    output logic             rsp_wr,
    output logic             rsp_timeout,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             pcpi_valid,
    output logic [31:0]      pcpi_insn,
    output logic [31:0]      pcpi_rs1,
    output logic [31:0]      pcpi_rs2,
    input  logic             pcpi_wr,
    input  logic [31:0]      pcpi_rd,
    input  logic             pcpi_wait,
    input  logic             pcpi_ready,
    output logic [31:0]      stat_done,
    output logic [31:0]      stat_timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_INIT = TW'(TIMEOUT - 1);

    state_t state, state_nx;
    logic [TW-1:0] tmo_cnt;
    logic accept, done, expire;

    always_comb begin
        state_nx   = state;
        cmd_ready  = 1'b0;
        pcpi_valid = 1'b0;
        rsp_valid  = 1'b0;
        accept     = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept   = 1'b1;
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                pcpi_valid = 1'b1;
                // completion takes priority over a coincident expiry
                if (pcpi_ready) begin
                    done     = 1'b1;
                    state_nx = ST_RESP;
                end else if (tmo_cnt == '0 && !pcpi_wait) begin
                    expire   = 1'b1;
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            tmo_cnt      <= '0;
            pcpi_insn    <= '0;
            pcpi_rs1     <= '0;
            pcpi_rs2     <= '0;
            rsp_rd       <= '0;
            rsp_wr       <= 1'b0;
            rsp_timeout  <= 1'b0;
            rsp_cycles   <= '0;
            stat_done    <= '0;
            stat_timeout <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                pcpi_insn  <= cmd_insn;
                pcpi_rs1   <= cmd_rs1;
                pcpi_rs2   <= cmd_rs2;
                tmo_cnt    <= TMO_INIT;
                rsp_cycles <= '0;
            end
            if (state == ST_ISSUE) begin
                if (rsp_cycles != '1) rsp_cycles <= rsp_cycles + CNT_W'(1);
                tmo_cnt <= pcpi_wait ? TMO_INIT : tmo_cnt - TW'(1);
            end
            if (done) begin
                rsp_wr      <= pcpi_wr;
                rsp_rd      <= pcpi_wr ? pcpi_rd : 32'h0;
                rsp_timeout <= 1'b0;
                stat_done   <= stat_done + 32'd1;
            end
            if (expire) begin
                rsp_wr       <= 1'b0;
                rsp_rd       <= 32'h0;
                rsp_timeout  <= 1'b1;
                stat_timeout <= stat_timeout + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_gf_pcpi_initiator.sv
// Scoreboard bench for gf_pcpi_initiator with a scripted
// coprocessor model driving wait/ready per transaction.
module tb_gf_pcpi_initiator;
    import gf_pcpi_pkg::*;

    localparam int TMO = 16;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_insn;
    logic [31:0] cmd_rs1;
    logic [31:0] cmd_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rd;
    logic        rsp_wr;
    logic        rsp_timeout;
    logic [15:0] rsp_cycles;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic [31:0] stat_done;
    logic [31:0] stat_timeout;

    gf_pcpi_initiator #(.TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_insn     (cmd_insn),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rd       (rsp_rd),
        .rsp_wr       (rsp_wr),
        .rsp_timeout  (rsp_timeout),
        .rsp_cycles   (rsp_cycles),
        .pcpi_valid   (pcpi_valid),
        .pcpi_insn    (pcpi_insn),
        .pcpi_rs1     (pcpi_rs1),
        .pcpi_rs2     (pcpi_rs2),
        .pcpi_wr      (pcpi_wr),
        .pcpi_rd      (pcpi_rd),
        .pcpi_wait    (pcpi_wait),
        .pcpi_ready   (pcpi_ready),
        .stat_done    (stat_done),
        .stat_timeout (stat_timeout)
    );

    typedef struct {
        logic [31:0] rd;
        logic        wr;
        logic        tmo;
        int          cyc;
        int          done;
        int          tout;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int exp_done = 0;
    int exp_tmo = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference timeout behaviour: which cycle ends the transaction, and how.
    function automatic exp_t model(input int wf, input int wt, input int ra,
                                   input bit wr, input logic [31:0] rd);
        exp_t e;
        int cnt;
        bit w;
        e.rd = 32'h0; e.wr = 1'b0; e.tmo = 1'b0; e.cyc = 0;
        e.done = 0; e.tout = 0;
        cnt = TMO - 1;
        for (int k = 1; k < 1000; k++) begin
            w = (k >= wf && k <= wt);
            if (k == ra) begin
                e.rd = wr ? rd : 32'h0;
                e.wr = wr;
                e.cyc = k;
                return e;
            end
            if (cnt == 0 && !w) begin
                e.tmo = 1'b1;
                e.cyc = k;
                return e;
            end
            cnt = w ? TMO - 1 : cnt - 1;
        end
        return e;
    endfunction

    task automatic push_exp(input int wf, input int wt, input int ra,
                            input bit wr, input logic [31:0] rd,
                            output int cyc);
        exp_t e;
        e = model(wf, wt, ra, wr, rd);
        if (e.tmo) exp_tmo++;
        else exp_done++;
        e.done = exp_done;
        e.tout = exp_tmo;
        cyc = e.cyc;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] insn, input logic [31:0] rs1,
                        input logic [31:0] rs2);
        chk("cmd_ready_idle", {31'h0, cmd_ready}, 32'h1);
        cmd_valid = 1'b1;
        cmd_insn  = insn;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pcpi_valid_start", {31'h0, pcpi_valid}, 32'h1);
        chk("pcpi_insn", pcpi_insn, insn);
        chk("pcpi_rs1", pcpi_rs1, rs1);
        chk("pcpi_rs2", pcpi_rs2, rs2);
    endtask

    task automatic run_copro(input int wf, input int wt, input int ra,
                             input bit wr, input logic [31:0] rd,
                             output int n);
        n = 0;
        while (pcpi_valid === 1'b1 && n < 400) begin
            n++;
            pcpi_wait  = (n >= wf && n <= wt);
            pcpi_ready = (n == ra);
            pcpi_wr    = (n == ra) ? wr : 1'b0;
            pcpi_rd    = rd;
            @(negedge clk);
        end
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
    endtask

    task automatic check_rsp(input int hold);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_size", sb.size(), 32'd1);
            return;
        end
        e = sb.pop_front();
        for (int i = 0; i <= hold; i++) begin
            chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
            chk("rsp_rd", rsp_rd, e.rd);
            chk("rsp_wr", {31'h0, rsp_wr}, {31'h0, e.wr});
            chk("rsp_timeout", {31'h0, rsp_timeout}, {31'h0, e.tmo});
            chk("rsp_cycles", {16'h0, rsp_cycles}, e.cyc);
            chk("stat_done", stat_done, e.done);
            chk("stat_timeout", stat_timeout, e.tout);
            chk("cmd_ready_resp", {31'h0, cmd_ready}, 32'h0);
            chk("pcpi_valid_resp", {31'h0, pcpi_valid}, 32'h0);
            if (i < hold) @(negedge clk);
        end
    endtask

    task automatic ack();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", {31'h0, rsp_valid}, 32'h0);
    endtask

    task automatic txn(input logic [31:0] insn, input logic [31:0] rs1,
                       input logic [31:0] rs2, input int wf, input int wt,
                       input int ra, input bit wr, input logic [31:0] rd,
                       input int hold);
        int cyc;
        int n;
        push_exp(wf, wt, ra, wr, rd, cyc);
        send(insn, rs1, rs2);
        run_copro(wf, wt, ra, wr, rd, n);
        chk("valid_len", n, cyc);
        check_rsp(hold);
        ack();
    endtask

    initial begin
        int cyc;
        int n;
        logic [31:0] cmul;
        logic [31:0] glw;
        logic [31:0] mul;

        cmul = mk_rtype(FUNCT7_G, 5'd7, 5'd6, 3'd0, 5'd5);
        glw  = mk_rtype(FUNCT7_G, 5'd7, 5'd6, 3'd4, 5'd5);
        mul  = mk_rtype(FUNCT7_M, 5'd2, 5'd1, 3'd0, 5'd3);

        resetn = 1'b0;
        cmd_valid = 1'b0; cmd_insn = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        rsp_ready = 1'b0;
        pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk("rst_pcpi_valid", {31'h0, pcpi_valid}, 32'h0);
        chk("rst_pcpi_insn", pcpi_insn, 32'h0);
        chk("rst_pcpi_rs1", pcpi_rs1, 32'h0);
        chk("rst_pcpi_rs2", pcpi_rs2, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rsp_rd", rsp_rd, 32'h0);
        chk("rst_rsp_wr", {31'h0, rsp_wr}, 32'h0);
        chk("rst_rsp_timeout", {31'h0, rsp_timeout}, 32'h0);
        chk("rst_rsp_cycles", {16'h0, rsp_cycles}, 32'h0);
        chk("rst_stat_done", stat_done, 32'h0);
        chk("rst_stat_timeout", stat_timeout, 32'h0);

        // fast claim
        txn(cmul, 32'd3, 32'd7, 2, 4, 5, 1'b1, 32'h9, 0);
        // minimum latency, M-extension opcode
        txn(mul, 32'h1234_5678, 32'h9abc_def0, 0, -1, 1, 1'b1, 32'h55aa_00ff, 0);
        // unclaimed
        txn(cmul, 32'd1, 32'd2, 0, -1, 0, 1'b0, 32'h0, 0);
        // long wait, no write: result must be masked
        txn(glw, 32'd9, 32'd10, 1, 100, 101, 1'b0, 32'hdead_beef, 0);
        // ready on the expiry cycle
        txn(cmul, 32'd4, 32'd5, 0, -1, 16, 1'b1, 32'h77, 0);
        // ready on expiry after a reload by wait
        txn(cmul, 32'd6, 32'd8, 1, 3, 19, 1'b1, 32'h88, 0);
        // late ready after expiry
        txn(mul, 32'd11, 32'd12, 0, -1, 20, 1'b1, 32'h99, 0);

        // backpressure with next command pending
        push_exp(0, -1, 1, 1'b1, 32'h1234, cyc);
        send(cmul, 32'ha, 32'hb);
        run_copro(0, -1, 1, 1'b1, 32'h1234, n);
        chk("bp_valid_len", n, cyc);
        cmd_valid = 1'b1;
        cmd_insn  = glw;
        cmd_rs1   = 32'hc;
        cmd_rs2   = 32'hd;
        check_rsp(10);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_gap_valid", {31'h0, pcpi_valid}, 32'h0);
        chk("bp_gap_ready", {31'h0, cmd_ready}, 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_valid", {31'h0, pcpi_valid}, 32'h1);
        chk("bp_next_insn", pcpi_insn, glw);
        push_exp(2, 3, 4, 1'b1, 32'h4321, cyc);
        run_copro(2, 3, 4, 1'b1, 32'h4321, n);
        chk("bp2_valid_len", n, cyc);
        check_rsp(0);
        ack();

        // reset in the third issue cycle
        send(cmul, 32'd1, 32'd1);
        pcpi_wait = 1'b1;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {31'h0, pcpi_valid}, 32'h0);
        chk("rst_mid_rsp", {31'h0, rsp_valid}, 32'h0);
        chk("rst_mid_done", stat_done, 32'h0);
        chk("rst_mid_tmo", stat_timeout, 32'h0);
        resetn = 1'b1;
        pcpi_wait = 1'b0;
        exp_done = 0;
        exp_tmo = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rsp", {31'h0, rsp_valid}, 32'h0);
            chk("post_rst_valid", {31'h0, pcpi_valid}, 32'h0);
        end

        // after reset the statistics restart from zero
        txn(cmul, 32'd3, 32'd7, 2, 4, 5, 1'b1, 32'h9, 0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
